// File: rtl/mod_addsub_ctrl_if.sv
// Request/response and adder-side signal bundle for mod_addsub_ctrl.
// The slave modport is the sequencer; the master modport is its environment (requester plus adder).
interface mod_addsub_ctrl_if #(
  parameter int unsigned N = 1030
);
  logic         start;
  logic         op;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic [N-1:0] in_m;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic [N-1:0] add_a;
  logic [N-1:0] add_b;
  logic         add_subtract;
  logic [N:0]   add_result;

  modport slave (
    input  start, op, in_a, in_b, in_m, add_result,
    output busy, done, result, add_a, add_b, add_subtract
  );

  modport master (
    output start, op, in_a, in_b, in_m, add_result,
    input  busy, done, result, add_a, add_b, add_subtract
  );
endinterface

// File: rtl/mod_addsub_ctrl.sv
// Two-pass modular add/subtract sequencer driving an external registered N-bit adder.
// Define MOD_ADDSUB_SUB_EN to honour op (modular subtract); otherwise only modular add is built.
module mod_addsub_ctrl #(
  parameter int unsigned N = 1030
) (
  input  logic                clk,
  input  logic                resetn,
  mod_addsub_ctrl_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PASS1 = 3'd1,
    CAP1  = 3'd2,
    PASS2 = 3'd3,
    CAP2  = 3'd4
  } state_t;

  state_t       state;
  state_t       state_next;
  logic [N-1:0] m_q;
  logic [N-1:0] t_q;
  logic [N-1:0] u;
  logic         f2;
`ifdef MOD_ADDSUB_SUB_EN
  logic         op_q;
  logic         f1_q;
`endif

  assign u       = bus.add_result[N-1:0];
  assign f2      = bus.add_result[N];
  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = PASS1;
      PASS1:   state_next = CAP1;
      CAP1:    state_next = PASS2;
      PASS2:   state_next = CAP2;
      CAP2:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Adder operands are registered one state early so they are stable for the whole PASS cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_q              <= '0;
      t_q              <= '0;
      bus.add_a        <= '0;
      bus.add_b        <= '0;
      bus.add_subtract <= 1'b0;
      bus.result       <= '0;
      bus.done         <= 1'b0;
`ifdef MOD_ADDSUB_SUB_EN
      op_q             <= 1'b0;
      f1_q             <= 1'b0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            bus.add_a <= bus.in_a;
            bus.add_b <= bus.in_b;
            m_q       <= bus.in_m;
`ifdef MOD_ADDSUB_SUB_EN
            op_q             <= bus.op;
            bus.add_subtract <= bus.op;
`else
            bus.add_subtract <= 1'b0;
`endif
          end
        end
        CAP1: begin
          t_q       <= u;
          bus.add_a <= u;
          bus.add_b <= m_q;
`ifdef MOD_ADDSUB_SUB_EN
          f1_q             <= f2;
          bus.add_subtract <= ~op_q;
`else
          bus.add_subtract <= 1'b1;
`endif
        end
        CAP2: begin
          // Subtract: u = t+M wraps mod 2^N, giving a-b+M when pass 1 borrowed.
`ifdef MOD_ADDSUB_SUB_EN
          if (op_q) bus.result <= f1_q ? u : t_q;
          else      bus.result <= f2 ? t_q : u;
`else
          bus.result <= f2 ? t_q : u;
`endif
          bus.done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
